// File: rtl/led_timer_bank.sv
// Multi-channel LED timer: each channel has a runtime-programmable period, compare and mode.
// Period/compare writes are shadowed while running and retune glitch-free at terminal count.
module led_timer_chan #(
   parameter int WIDTH      = 26,
   parameter int DEF_PERIOD = 25_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_sel,
   input  logic [1:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic             led,
   output logic             tick
);
   typedef enum logic [1:0] {M_TOG = 2'b00, M_PWM = 2'b01, M_ONE = 2'b10, M_TOG2 = 2'b11} mode_e;

   localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEF_PERIOD);
   localparam logic [WIDTH-1:0] DEF_C = WIDTH'(DEF_PERIOD / 2);

   logic [WIDTH-1:0] p, c, ps, cs, cnt, last;
   logic             en, tc, wr_p, wr_c, wr_ctl;
   mode_e            mode;

   // Period 0 behaves as period 1: terminal count on every enabled cycle.
   always_comb begin
      last   = (p == '0) ? '0 : p - 1'b1;
      tc     = en && (cnt >= last);
      wr_p   = wr_sel && (wr_addr == 2'd0);
      wr_c   = wr_sel && (wr_addr == 2'd1);
      wr_ctl = wr_sel && (wr_addr == 2'd2);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p    <= DEF_P;
         ps   <= DEF_P;
         c    <= DEF_C;
         cs   <= DEF_C;
         cnt  <= '0;
         en   <= 1'b0;
         mode <= M_TOG;
         led  <= 1'b0;
         tick <= 1'b0;
      end else begin
         // A write landing on the terminal edge goes straight to the active register.
         if (wr_p) begin
            ps <= wr_data;
            if (!en || tc) p <= wr_data;
         end else if (tc) begin
            p <= ps;
         end
         if (wr_c) begin
            cs <= wr_data;
            if (!en || tc) c <= wr_data;
         end else if (tc) begin
            c <= cs;
         end

         if (wr_ctl) begin
            en   <= wr_data[0];
            mode <= mode_e'(wr_data[2:1]);
            cnt  <= '0;
            tick <= 1'b0;
            led  <= wr_data[0] && (wr_data[2:1] == M_ONE);
         end else if (tc) begin
            cnt  <= '0;
            tick <= 1'b1;
            case (mode)
               M_ONE: begin
                  led <= 1'b0;
                  en  <= 1'b0;
               end
               M_PWM:   led <= (cnt < c);
               default: led <= ~led;
            endcase
         end else begin
            tick <= 1'b0;
            if (en) begin
               cnt <= cnt + 1'b1;
               if (mode == M_PWM) led <= (cnt < c);
            end
         end
      end
   end
endmodule

module led_timer_bank #(
   parameter int CHANNELS   = 8,
   parameter int WIDTH      = 26,
   parameter int DEF_PERIOD = 25_000_000,
   localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [CW-1:0]       wr_ch,
   input  logic [1:0]          wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   output logic [CHANNELS-1:0] led,
   output logic [CHANNELS-1:0] tick
);
   logic [CHANNELS-1:0] wr_sel;

   // Out-of-range channel numbers match no decoder and are dropped.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      assign wr_sel[i] = wr_en && (wr_ch == CW'(i));

      led_timer_chan #(.WIDTH(WIDTH), .DEF_PERIOD(DEF_PERIOD)) u_chan (
         .clk    (clk),
         .rst_n  (rst_n),
         .wr_sel (wr_sel[i]),
         .wr_addr(wr_addr),
         .wr_data(wr_data),
         .led    (led[i]),
         .tick   (tick[i])
      );
   end
endmodule

// File: tb/tb_led_timer_bank.sv
// Directed-vector bench for led_timer_bank; tick/led traces are compared as bit masks
// where bit k is the output value sampled just after edge (write edge + k + 1).
module tb_led_timer_bank;
   localparam int CH = 8;
   localparam int W  = 26;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [2:0]    wr_ch = '0;
   logic [1:0]    wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic [CH-1:0] led, tick;

   int nvec = 0;
   int nerr = 0;

   led_timer_bank #(.CHANNELS(CH), .WIDTH(W), .DEF_PERIOD(25_000_000)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .wr_ch  (wr_ch),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .led    (led),
      .tick   (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_raw(input logic en, input int ch, input int a, input int d);
      wr_en   = en;
      wr_ch   = 3'(ch);
      wr_addr = 2'(a);
      wr_data = W'(d);
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wr(input int ch, input int a, input int d);
      wr_raw(1'b1, ch, a, d);
   endtask

   task automatic trace(input int ch, input int n, output logic [63:0] tk, output logic [63:0] ld);
      tk = '0;
      ld = '0;
      for (int i = 1; i <= n; i++) begin
         step();
         tk[i-1] = tick[ch];
         ld[i-1] = led[ch];
      end
   endtask

   initial begin
      logic [63:0] tk, ld;
      logic [CH-1:0] acc;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rst_led", 64'(led), 64'h0);
      chk("rst_tick", 64'(tick), 64'h0);

      // toggle, P=4
      wr(0, 0, 4);
      wr(0, 2, 1);
      trace(0, 12, tk, ld);
      chk("tog_tick", tk, 64'h888);
      chk("tog_led", ld, 64'h878);

      // asynchronous reset mid-count with led[0] high
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("async_rst_led", 64'(led), 64'h0);
      chk("async_rst_tick", 64'(tick), 64'h0);
      #5;
      rst_n = 1'b1;
      acc = '0;
      for (int i = 0; i < 100; i++) begin
         step();
         acc |= led | tick;
      end
      chk("idle_100", 64'(acc), 64'h0);

      // P=1: tick every cycle
      wr(1, 0, 1);
      wr(1, 2, 1);
      trace(1, 8, tk, ld);
      chk("p1_tick", tk, 64'hFF);
      chk("p1_led", ld, 64'h55);

      // P=0 behaves as P=1
      wr(5, 0, 0);
      wr(5, 2, 1);
      trace(5, 8, tk, ld);
      chk("p0_tick", tk, 64'hFF);

      // PWM P=10 C=3
      wr(2, 0, 10);
      wr(2, 1, 3);
      wr(2, 2, 3);
      trace(2, 20, tk, ld);
      chk("pwm3_led", ld, 64'h1C07);
      chk("pwm3_tick", tk, 64'h80200);
      wr(2, 2, 0);
      wr(2, 1, 0);
      wr(2, 2, 3);
      trace(2, 20, tk, ld);
      chk("pwm0_led", ld, 64'h0);
      wr(2, 2, 0);
      wr(2, 1, 12);
      wr(2, 2, 3);
      trace(2, 20, tk, ld);
      chk("pwm12_led", ld, 64'hFFFFF);

      // one-shot P=5
      wr(3, 0, 5);
      wr(3, 2, 5);
      chk("os_start_led", 64'(led[3]), 64'h1);
      trace(3, 10, tk, ld);
      chk("os_led", ld, 64'hF);
      chk("os_tick", tk, 64'h10);
      trace(3, 50, tk, ld);
      chk("os_after_tick", tk, 64'h0);
      chk("os_after_led", ld, 64'h0);

      // retune while running: 8 -> 3 mid-period, then 3 -> 5 on the terminal edge
      wr(4, 0, 8);
      wr(4, 2, 1);
      step();
      step();
      step();
      wr(4, 0, 3);
      trace(4, 10, tk, ld);
      chk("retune_tick", tk, 64'h248);
      step();
      step();
      wr(4, 0, 5);
      chk("tc_write_tick", 64'(tick[4]), 64'h1);
      trace(4, 10, tk, ld);
      chk("tc_write_period", tk, 64'h210);

      // invalid writes: addr 3, and a strobe-less ctrl pattern
      wr(6, 0, 4);
      wr(6, 2, 1);
      wr(6, 3, 0);
      wr_raw(1'b0, 6, 2, 0);
      trace(6, 8, tk, ld);
      chk("invalid_wr_tick", tk, 64'h22);

      // isolation: disabling ch6 leaves ch7 and ch1 undisturbed
      wr(7, 0, 6);
      wr(7, 2, 1);
      step();
      step();
      wr(6, 2, 0);
      trace(7, 10, tk, ld);
      chk("iso_tick", tk, 64'h104);
      chk("iso_led", ld, 64'hFC);
      chk("iso_ch6_off", 64'({led[6], tick[6]}), 64'h0);
      chk("iso_ch1_tick", 64'(tick[1]), 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/led_timer_bank.md
# led_timer_bank

Multi-channel programmable LED timer for the board-level timer designs. Each of `CHANNELS` channels has its own runtime-loadable period, compare value and mode (square-wave toggle, PWM, one-shot), replacing per-channel fixed-divider instances elaborated with compile-time constants. The block sits between the 50 MHz board clock and the LED bank. A simple single-cycle register-write port lets a controller or switch logic reprogram channels without a rebuild.

## Interface
- `CHANNELS`, 8: number of independent channels (1..16).
- `WIDTH`, 26: counter, period and compare width in bits.
- `DEF_PERIOD`, 25_000_000: period loaded into every channel at reset.
- `clk` in 1: system clock (CLOCK_50 at top level).
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `wr_en` in 1: write strobe, one write per cycle.
- `wr_ch` in `clog2(CHANNELS)` (min 1): target channel; values >= `CHANNELS` are ignored.
- `wr_addr` in 2: register select. 0 = period, 1 = compare, 2 = ctrl, 3 = ignored.
- `wr_data` in `WIDTH`: write data. Ctrl uses bit0 = enable and bits[2:1] = mode (00 toggle, 01 PWM, 10 one-shot, 11 treated as toggle).
- `led` out `CHANNELS`: registered per-channel LED outputs.
- `tick` out `CHANNELS`: one-cycle pulse at each channel terminal count.

## Operation
- **Per-channel state:** active period P, active compare C, shadow period Ps, shadow compare Cs, ctrl (enable, mode), counter cnt (`WIDTH` bits).
- **Reset values:**
  - P = Ps = `DEF_PERIOD`; C = Cs = `DEF_PERIOD`/2.
  - ctrl = 0; cnt = 0; led = 0; tick = 0.
- **Period/compare writes:**
  - Writes go to Ps/Cs.
  - When the channel is disabled, P/C also load on the same edge.
  - When enabled, P/C load from shadow only at the terminal count (glitch-free retune).
  - A write coinciding with a terminal count bypasses the shadow: the newly written value becomes active on that edge.
- **Period 0 is treated as 1:** terminal count every cycle.
- **Terminal count:** enabled and cnt == P-1. On that edge cnt <= 0 and tick <= 1; otherwise cnt <= cnt+1 and tick <= 0.
- **Toggle mode:** led inverts at each terminal count, giving an output period of 2P cycles and 50% duty.
- **PWM mode:** led <= (cnt < C). High exactly C cycles of every P; C = 0 gives constant 0; C >= P gives constant 1.
- **One-shot mode:**
  - On enable, led <= 1 and counting starts.
  - At the first terminal count: led <= 0, tick pulses, enable bit self-clears, cnt <= 0.
- **Ctrl write with enable = 1:**
  - Restarts the channel: cnt <= 0, tick <= 0.
  - led <= 1 for one-shot, 0 otherwise.
  - Mode changes take effect on that edge.
- **Ctrl write with enable = 0:** cnt <= 0, led <= 0, tick <= 0; the channel is frozen.
- **Channel independence:** channels never interact. A write affects only `wr_ch`, and all other channels keep counting undisturbed.
- **Wrap-around:** cnt never exceeds P-1. A period written smaller than the current cnt while disabled is safe because disable already cleared cnt.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Write latency: a register write sampled at edge n is visible in behaviour from edge n.
- First tick after an enabling ctrl write at edge n occurs at edge n+P.
- Toggle mode: led transitions at edges n+P, n+2P, and so on.
- PWM mode: led trails cnt by one cycle.
- tick is high for exactly one cycle per terminal count, and stays high every cycle when P <= 1.
- Asynchronous reset:
  - Assertion clears all outputs immediately, including mid-count and mid-one-shot.
  - Deassertion: the first counting edge is the first rising `clk` after release. Channels remain disabled until written.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-count -> led = 0 and tick = 0 immediately. After release, all channels stay idle for 100 cycles.
- **Toggle:**
  - ch0 period = 4, ctrl = 001 -> tick at n+4, n+8, n+12, ...; led toggles at the same edges.
  - ch1 P = 1 -> tick high every cycle.
- **PWM:**
  - ch2 P = 10, C = 3, mode 01 -> led high 3 of every 10 cycles.
  - C = 0 -> always 0; C = 12 -> always 1.
- **One-shot:** ch3 P = 5, mode 10 -> led = 1 for 5 cycles, a single tick, enable reads self-cleared, and no further ticks after 50 cycles.
- **Retune while running:**
  - ch4 P = 8 running; write P = 3 mid-period -> the current period completes at 8, and subsequent periods are 3.
  - A write on the terminal edge takes effect immediately.
- **Isolation and invalid writes:**
  - Writes to `wr_ch` = `CHANNELS` and to `wr_addr` = 3 -> no channel changes.
  - Disabling ch0 leaves ch1..ch7 tick timing unchanged.
